// File: rtl/mc_ctrl.sv
// Multicycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB with a sticky TRAP state.
// Optional MEM wait-cycle timeout is enabled by defining MC_CTRL_TIMEOUT_EN.
module mc_ctrl #(
  parameter int MEM_TIMEOUT = 8
) (
  input  logic        clk,
  input  logic        rstd,
  input  logic        run,
  input  logic [5:0]  op,
  input  logic        mem_ready,
  output logic [2:0]  state,
  output logic        ir_load,
  output logic        pc_wren,
  output logic        rf_wren_n,
  output logic        mem_req,
  output logic [3:0]  dm_wren_n,
  output logic        busy,
  output logic        err,
  output logic [1:0]  err_code,
  output logic [31:0] instret
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    TRAP   = 3'd6
  } state_t;

  state_t     cur, nxt;
  logic [1:0] ec_nxt;
  logic       retire;
  logic       is_alu, is_load, is_store, is_branch;

  // A zero timeout would make MEM trap before it could ever complete.
  if (MEM_TIMEOUT < 1) begin : g_bad_timeout
  end

  assign is_alu    = op inside {6'd0, 6'd1, 6'd3, 6'd4, 6'd5, 6'd6, 6'd41};
  assign is_load   = op inside {6'd16, 6'd18, 6'd20};
  assign is_store  = op inside {6'd24, 6'd26, 6'd28};
  assign is_branch = op inside {6'd32, 6'd33, 6'd34, 6'd35, 6'd40, 6'd42};

`ifdef MC_CTRL_TIMEOUT_EN
  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] LAST_WAIT = CW'(MEM_TIMEOUT - 1);
  logic [CW-1:0] wait_cnt, cnt_nxt;
`endif

  // Handshake: mem_req stays high for the whole MEM visit; the access completes
  // on the first cycle mem_ready=1 is seen while mem_req=1. mem_ready is ignored elsewhere.
  always_comb begin
    nxt       = cur;
    ec_nxt    = err_code;
    retire    = 1'b0;
    pc_wren   = 1'b0;
    dm_wren_n = 4'b1111;
`ifdef MC_CTRL_TIMEOUT_EN
    cnt_nxt   = wait_cnt;
`endif
    case (cur)
      IDLE:   if (run) nxt = FETCH;
      FETCH:  nxt = DECODE;
      DECODE: nxt = EXEC;
      EXEC: begin
        if (is_alu) begin
          nxt = WB;
        end else if (is_load || is_store) begin
          nxt = MEM;
`ifdef MC_CTRL_TIMEOUT_EN
          cnt_nxt = '0;
`endif
        end else if (is_branch) begin
          pc_wren = 1'b1;
          retire  = 1'b1;
          nxt     = run ? FETCH : IDLE;
        end else begin
          nxt    = TRAP;
          ec_nxt = 2'd1;
        end
      end
      MEM: begin
        case (op)
          6'd24:   dm_wren_n = 4'b0000;
          6'd26:   dm_wren_n = 4'b1100;
          6'd28:   dm_wren_n = 4'b1110;
          default: dm_wren_n = 4'b1111;
        endcase
        if (mem_ready) begin
`ifdef MC_CTRL_TIMEOUT_EN
          cnt_nxt = '0;
`endif
          if (is_store) begin
            pc_wren = 1'b1;
            retire  = 1'b1;
            nxt     = run ? FETCH : IDLE;
          end else begin
            nxt = WB;
          end
        end else begin
`ifdef MC_CTRL_TIMEOUT_EN
          if (wait_cnt == LAST_WAIT) begin
            nxt    = TRAP;
            ec_nxt = 2'd2;
          end
          cnt_nxt = wait_cnt + 1'b1;
`endif
        end
      end
      WB: begin
        pc_wren = 1'b1;
        retire  = 1'b1;
        nxt     = run ? FETCH : IDLE;
      end
      TRAP:    nxt = TRAP;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstd) begin
    if (!rstd) begin
      cur      <= IDLE;
      err_code <= 2'd0;
      instret  <= 32'd0;
`ifdef MC_CTRL_TIMEOUT_EN
      wait_cnt <= '0;
`endif
    end else begin
      cur      <= nxt;
      err_code <= ec_nxt;
      if (retire) instret <= instret + 32'd1;
`ifdef MC_CTRL_TIMEOUT_EN
      wait_cnt <= cnt_nxt;
`endif
    end
  end

  assign state     = cur;
  assign ir_load   = (cur == FETCH);
  assign rf_wren_n = (cur != WB);
  assign mem_req   = (cur == MEM);
  assign busy      = (cur != IDLE) && (cur != TRAP);
  assign err       = (cur == TRAP);

endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: a per-instruction model expands each op into its expected cycle
// sequence, which is then replayed against the DUT and compared every cycle.
module tb_mc_ctrl;

  localparam int MEM_TIMEOUT = 8;

  logic        clk, rstd, run, mem_ready;
  logic [5:0]  op;
  logic [2:0]  state;
  logic        ir_load, pc_wren, rf_wren_n, mem_req, busy, err;
  logic [3:0]  dm_wren_n;
  logic [1:0]  err_code;
  logic [31:0] instret;

  int checks = 0;
  int errors = 0;

  // Expected outputs per cycle: {state, ir_load, pc_wren, rf_wren_n, mem_req, dm_wren_n, busy, err}
  logic [12:0] exp_q[$];
  // Per-cycle control: {set_err_code[1:0], retire, run, mem_ready}
  logic [4:0]  ctl_q[$];
  logic [5:0]  op_q[$];

  logic [31:0] exp_instret;
  logic [1:0]  exp_ec;
  bit          in_idle;

  mc_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk(clk), .rstd(rstd), .run(run), .op(op), .mem_ready(mem_ready),
    .state(state), .ir_load(ir_load), .pc_wren(pc_wren), .rf_wren_n(rf_wren_n),
    .mem_req(mem_req), .dm_wren_n(dm_wren_n), .busy(busy), .err(err),
    .err_code(err_code), .instret(instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  function automatic logic [12:0] mk(input logic [2:0] s, input logic ir, input logic pc,
                                      input logic rfn, input logic mreq, input logic [3:0] dm);
    logic b, e;
    b = (s != 3'd0) && (s != 3'd6);
    e = (s == 3'd6);
    return {s, ir, pc, rfn, mreq, dm, b, e};
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push(input logic [12:0] e, input logic [5:0] o, input logic r,
                      input logic mr, input logic ret, input logic [1:0] ec);
    exp_q.push_back(e);
    ctl_q.push_back({ec, ret, r, mr});
    op_q.push_back(o);
  endtask

  // Expand one instruction into the cycles it should take.
  task automatic gen_instr(input int opc, input int w, input bit mid_rand, input bit run_end);
    logic [5:0] o;
    logic [3:0] dm;
    bit alu, ld, st, br;
    o   = 6'(opc);
    alu = opc inside {0, 1, 3, 4, 5, 6, 41};
    ld  = opc inside {16, 18, 20};
    st  = opc inside {24, 26, 28};
    br  = opc inside {32, 33, 34, 35, 40, 42};
    dm  = (opc == 24) ? 4'b0000 : (opc == 26) ? 4'b1100 : (opc == 28) ? 4'b1110 : 4'b1111;
    if (in_idle) begin
      repeat ($urandom_range(0, 2)) push(mk(3'd0, 0, 0, 1, 0, 4'hf), o, 1'b0, rbit(), 0, 2'd0);
      push(mk(3'd0, 0, 0, 1, 0, 4'hf), o, 1'b1, rbit(), 0, 2'd0);
    end
    push(mk(3'd1, 1, 0, 1, 0, 4'hf), o, mid_rand ? rbit() : 1'b1, rbit(), 0, 2'd0);
    push(mk(3'd2, 0, 0, 1, 0, 4'hf), o, mid_rand ? rbit() : 1'b1, rbit(), 0, 2'd0);
    if (br) begin
      push(mk(3'd3, 0, 1, 1, 0, 4'hf), o, run_end, rbit(), 1, 2'd0);
      in_idle = !run_end;
      return;
    end
    if (!(alu || ld || st)) begin
      push(mk(3'd3, 0, 0, 1, 0, 4'hf), o, rbit(), rbit(), 0, 2'd1);
      in_idle = 0;
      return;
    end
    push(mk(3'd3, 0, 0, 1, 0, 4'hf), o, mid_rand ? rbit() : 1'b1, rbit(), 0, 2'd0);
    if (ld || st) begin
      for (int i = 0; i < w; i++) begin
`ifdef MC_CTRL_TIMEOUT_EN
        if (i == MEM_TIMEOUT - 1) begin
          push(mk(3'd4, 0, 0, 1, 1, dm), o, rbit(), 1'b0, 0, 2'd2);
          in_idle = 0;
          return;
        end
`endif
        push(mk(3'd4, 0, 0, 1, 1, dm), o, mid_rand ? rbit() : 1'b1, 1'b0, 0, 2'd0);
      end
      if (st) begin
        push(mk(3'd4, 0, 1, 1, 1, dm), o, run_end, 1'b1, 1, 2'd0);
        in_idle = !run_end;
        return;
      end
      push(mk(3'd4, 0, 0, 1, 1, dm), o, mid_rand ? rbit() : 1'b1, 1'b1, 0, 2'd0);
    end
    push(mk(3'd5, 0, 1, 0, 0, 4'hf), o, run_end, rbit(), 1, 2'd0);
    in_idle = !run_end;
  endtask

  task automatic gen_trap(input int n);
    repeat (n) push(mk(3'd6, 0, 0, 1, 0, 4'hf), 6'($urandom_range(0, 63)), rbit(), rbit(), 0, 2'd0);
  endtask

  task automatic check_cycle(input logic [12:0] e);
    logic [12:0] obs;
    obs = {state, ir_load, pc_wren, rf_wren_n, mem_req, dm_wren_n, busy, err};
    checks++;
    assert (obs === e) else begin
      errors++;
      $error("FAIL outputs t=%0t obs=%h exp=%h", $time, obs, e);
    end
    checks++;
    assert (instret === exp_instret) else begin
      errors++;
      $error("FAIL instret t=%0t obs=%0d exp=%0d", $time, instret, exp_instret);
    end
    checks++;
    assert (err_code === exp_ec) else begin
      errors++;
      $error("FAIL err_code t=%0t obs=%0d exp=%0d", $time, err_code, exp_ec);
    end
  endtask

  task automatic drain_n(input int n);
    logic [12:0] e;
    logic [4:0]  c;
    for (int i = 0; i < n && exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      c = ctl_q.pop_front();
      @(negedge clk);
      op        = op_q.pop_front();
      run       = c[1];
      mem_ready = c[0];
      #1;
      check_cycle(e);
      if (c[2]) exp_instret++;
      if (c[4:3] != 2'd0) exp_ec = c[4:3];
    end
  endtask

  task automatic drain();
    drain_n(exp_q.size());
  endtask

  task automatic do_reset();
    exp_q.delete();
    ctl_q.delete();
    op_q.delete();
    @(negedge clk);
    #2;
    rstd      = 1'b0;
    run       = rbit();
    mem_ready = rbit();
    exp_instret = 32'd0;
    exp_ec      = 2'd0;
    in_idle     = 1;
    #1;
    check_cycle(mk(3'd0, 0, 0, 1, 0, 4'hf));
    @(negedge clk);
    #1;
    check_cycle(mk(3'd0, 0, 0, 1, 0, 4'hf));
    rstd = 1'b1;
    run  = 1'b0;
  endtask

  initial begin
    rstd = 1'b0; run = 1'b0; op = 6'd0; mem_ready = 1'b0;
    exp_instret = 0; exp_ec = 0; in_idle = 1;
    do_reset();

    // Idle with run low: nothing moves.
    repeat (2) push(mk(3'd0, 0, 0, 1, 0, 4'hf), 6'd0, 1'b0, rbit(), 0, 2'd0);
    drain();

    // ALU stream.
    repeat (3) gen_instr(0, 0, 0, 1);
    drain();
    // Store with two wait cycles, then an immediate load.
    gen_instr(24, 2, 0, 1);
    gen_instr(20, 0, 0, 1);
    drain();
    // Branch with run dropped in EXEC, then sit in IDLE.
    gen_instr(32, 0, 0, 0);
    push(mk(3'd0, 0, 0, 1, 0, 4'hf), 6'd0, 1'b0, rbit(), 0, 2'd0);
    drain();

    // Randomized legal instruction mix.
    for (int i = 0; i < 60; i++) begin
      int legal[22] = '{0, 1, 3, 4, 5, 6, 41, 16, 18, 20, 24, 26, 28, 32, 33, 34, 35, 40, 42, 0, 24, 16};
      gen_instr(legal[$urandom_range(0, 21)], $urandom_range(0, 5), 1, 1'($urandom_range(0, 1)));
      drain();
    end

`ifdef MC_CTRL_TIMEOUT_EN
    gen_instr(16, MEM_TIMEOUT, 0, 1);
    gen_trap(4);
    drain();
`else
    gen_instr(28, 12, 0, 1);
    drain();
`endif
    do_reset();

    // Reset in the middle of a store: nothing retires.
    gen_instr(26, 3, 0, 1);
    drain_n(exp_q.size() - 1);
    do_reset();

    // Illegal opcode traps and stays trapped regardless of run.
    gen_instr(5, 0, 0, 1);
    gen_instr(7, 0, 0, 1);
    gen_trap(6);
    drain();
    do_reset();
    gen_instr(42, 0, 0, 1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
